// File: rtl/axi_read_router.sv
// axi_read_router
// Read-channel crossbar stage: two masters (M0 = CPU IM, M1 = CPU DM) share
// three read targets (S0 ROM/IM, S1 DM, SD default slave). A single read is
// outstanding at a time. AR is latched, decoded and forwarded one cycle after
// it is sampled; the R burst is then passed straight through until the slave
// flags RLAST.
// Build option: define AXI_RR_ARB_EN for round-robin arbitration between the
// masters; without it M1 always wins over M0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no read in flight; arbitrate and latch a pending AR
// ADDR  | forward latched AR to the selected slave, wait for ARREADY
// DATA  | pass the R burst through until the slave's last beat
module axi_read_router #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // master 0
    input  logic [3:0]  M0_ARID,
    input  logic [31:0] M0_ARADDR,
    input  logic [3:0]  M0_ARLEN,
    input  logic [2:0]  M0_ARSIZE,
    input  logic [1:0]  M0_ARBURST,
    input  logic        M0_ARVALID,
    output logic        M0_ARREADY,
    output logic [3:0]  M0_RID,
    output logic [31:0] M0_RDATA,
    output logic [1:0]  M0_RRESP,
    output logic        M0_RLAST,
    output logic        M0_RVALID,
    input  logic        M0_RREADY,
    // master 1
    input  logic [3:0]  M1_ARID,
    input  logic [31:0] M1_ARADDR,
    input  logic [3:0]  M1_ARLEN,
    input  logic [2:0]  M1_ARSIZE,
    input  logic [1:0]  M1_ARBURST,
    input  logic        M1_ARVALID,
    output logic        M1_ARREADY,
    output logic [3:0]  M1_RID,
    output logic [31:0] M1_RDATA,
    output logic [1:0]  M1_RRESP,
    output logic        M1_RLAST,
    output logic        M1_RVALID,
    input  logic        M1_RREADY,
    // slave 0
    output logic [7:0]  S0_ARID,
    output logic [31:0] S0_ARADDR,
    output logic [3:0]  S0_ARLEN,
    output logic [2:0]  S0_ARSIZE,
    output logic [1:0]  S0_ARBURST,
    output logic        S0_ARVALID,
    input  logic        S0_ARREADY,
    input  logic [7:0]  S0_RID,
    input  logic [31:0] S0_RDATA,
    input  logic [1:0]  S0_RRESP,
    input  logic        S0_RLAST,
    input  logic        S0_RVALID,
    output logic        S0_RREADY,
    // slave 1
    output logic [7:0]  S1_ARID,
    output logic [31:0] S1_ARADDR,
    output logic [3:0]  S1_ARLEN,
    output logic [2:0]  S1_ARSIZE,
    output logic [1:0]  S1_ARBURST,
    output logic        S1_ARVALID,
    input  logic        S1_ARREADY,
    input  logic [7:0]  S1_RID,
    input  logic [31:0] S1_RDATA,
    input  logic [1:0]  S1_RRESP,
    input  logic        S1_RLAST,
    input  logic        S1_RVALID,
    output logic        S1_RREADY,
    // default slave
    output logic [7:0]  SD_ARID,
    output logic [31:0] SD_ARADDR,
    output logic [3:0]  SD_ARLEN,
    output logic [2:0]  SD_ARSIZE,
    output logic [1:0]  SD_ARBURST,
    output logic        SD_ARVALID,
    input  logic        SD_ARREADY,
    input  logic [7:0]  SD_RID,
    input  logic [31:0] SD_RDATA,
    input  logic [1:0]  SD_RRESP,
    input  logic        SD_RLAST,
    input  logic        SD_RVALID,
    output logic        SD_RREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_S0 = 2'd0,
        SEL_S1 = 2'd1,
        SEL_SD = 2'd2
    } sel_t;

    state_t      state;
    state_t      state_nxt;
    sel_t        sel;
    logic        grant;
    logic        latch_ar;
    logic        burst_done;

    // latched AR of the granted master
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [3:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [7:0]  ar_fwd_id;

    // request presented by the arbitration winner
    logic        req_any;
    logic        req_grant;
    logic [3:0]  req_id;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    sel_t        req_sel;

    // selected slave's return signals
    logic        sel_arready;
    logic [3:0]  sel_rid;
    logic [31:0] sel_rdata;
    logic [1:0]  sel_rresp;
    logic        sel_rlast;
    logic        sel_rvalid;
    logic        grant_rready;

    // upper RID bits carry the routing tag added on the AR side and are dropped
    logic        unused_rid_hi;
    assign unused_rid_hi = ^{S0_RID[7:4], S1_RID[7:4], SD_RID[7:4]};

    function automatic sel_t decode(input logic [31:0] addr);
        if ((addr & S0_MASK) == S0_BASE) begin
            return SEL_S0;
        end else if ((addr & S1_MASK) == S1_BASE) begin
            return SEL_S1;
        end else begin
            return SEL_SD;
        end
    endfunction

`ifdef AXI_RR_ARB_EN
    logic rr_last;

    // Remember which master finished last so a tie goes to the other one.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_last <= 1'b1;
        end else if (burst_done) begin
            rr_last <= grant;
        end
    end

    // Round-robin: single requester wins, a tie goes to the master that did not finish last.
    always_comb begin
        req_any = M0_ARVALID | M1_ARVALID;
        if (M0_ARVALID && M1_ARVALID) begin
            req_grant = ~rr_last;
        end else begin
            req_grant = M1_ARVALID;
        end
    end
`else
    // Fixed priority: the data port (M1) always beats the instruction port (M0).
    always_comb begin
        req_any   = M0_ARVALID | M1_ARVALID;
        req_grant = M1_ARVALID;
    end
`endif

    // Select the winner's AR fields and decode its address for latching.
    always_comb begin
        if (req_grant) begin
            req_id    = M1_ARID;
            req_addr  = M1_ARADDR;
            req_len   = M1_ARLEN;
            req_size  = M1_ARSIZE;
            req_burst = M1_ARBURST;
        end else begin
            req_id    = M0_ARID;
            req_addr  = M0_ARADDR;
            req_len   = M0_ARLEN;
            req_size  = M0_ARSIZE;
            req_burst = M0_ARBURST;
        end
        req_sel = decode(req_addr);
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the latch / burst-end strobes.
    always_comb begin
        state_nxt  = state;
        latch_ar   = 1'b0;
        burst_done = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    latch_ar  = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (sel_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (sel_rvalid && grant_rready && sel_rlast) begin
                    burst_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture grant, target and AR fields when a request is accepted in IDLE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant    <= 1'b0;
            sel      <= SEL_SD;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
        end else if (latch_ar) begin
            grant    <= req_grant;
            sel      <= req_sel;
            ar_id    <= req_id;
            ar_addr  <= req_addr;
            ar_len   <= req_len;
            ar_size  <= req_size;
            ar_burst <= req_burst;
        end
    end

    assign ar_fwd_id    = {3'b000, grant, ar_id};
    assign grant_rready = grant ? M1_RREADY : M0_RREADY;

    // Mux the selected slave's handshake and R channel.
    always_comb begin
        sel_arready = 1'b0;
        sel_rid     = '0;
        sel_rdata   = '0;
        sel_rresp   = '0;
        sel_rlast   = 1'b0;
        sel_rvalid  = 1'b0;
        case (sel)
            SEL_S0: begin
                sel_arready = S0_ARREADY;
                sel_rid     = S0_RID[3:0];
                sel_rdata   = S0_RDATA;
                sel_rresp   = S0_RRESP;
                sel_rlast   = S0_RLAST;
                sel_rvalid  = S0_RVALID;
            end
            SEL_S1: begin
                sel_arready = S1_ARREADY;
                sel_rid     = S1_RID[3:0];
                sel_rdata   = S1_RDATA;
                sel_rresp   = S1_RRESP;
                sel_rlast   = S1_RLAST;
                sel_rvalid  = S1_RVALID;
            end
            SEL_SD: begin
                sel_arready = SD_ARREADY;
                sel_rid     = SD_RID[3:0];
                sel_rdata   = SD_RDATA;
                sel_rresp   = SD_RRESP;
                sel_rlast   = SD_RLAST;
                sel_rvalid  = SD_RVALID;
            end
            default: ;
        endcase
    end

    // AR channel: only the selected slave sees the request, only in ADDR.
    always_comb begin
        S0_ARID = '0; S0_ARADDR = '0; S0_ARLEN = '0; S0_ARSIZE = '0; S0_ARBURST = '0; S0_ARVALID = 1'b0;
        S1_ARID = '0; S1_ARADDR = '0; S1_ARLEN = '0; S1_ARSIZE = '0; S1_ARBURST = '0; S1_ARVALID = 1'b0;
        SD_ARID = '0; SD_ARADDR = '0; SD_ARLEN = '0; SD_ARSIZE = '0; SD_ARBURST = '0; SD_ARVALID = 1'b0;
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        if (state == ADDR) begin
            case (sel)
                SEL_S0: begin
                    S0_ARID = ar_fwd_id; S0_ARADDR = ar_addr; S0_ARLEN = ar_len;
                    S0_ARSIZE = ar_size; S0_ARBURST = ar_burst; S0_ARVALID = 1'b1;
                end
                SEL_S1: begin
                    S1_ARID = ar_fwd_id; S1_ARADDR = ar_addr; S1_ARLEN = ar_len;
                    S1_ARSIZE = ar_size; S1_ARBURST = ar_burst; S1_ARVALID = 1'b1;
                end
                SEL_SD: begin
                    SD_ARID = ar_fwd_id; SD_ARADDR = ar_addr; SD_ARLEN = ar_len;
                    SD_ARSIZE = ar_size; SD_ARBURST = ar_burst; SD_ARVALID = 1'b1;
                end
                default: ;
            endcase
            if (grant) begin
                M1_ARREADY = sel_arready;
            end else begin
                M0_ARREADY = sel_arready;
            end
        end
    end

    // R channel: zero-latency pass-through between granted master and selected slave in DATA.
    always_comb begin
        M0_RID = '0; M0_RDATA = '0; M0_RRESP = '0; M0_RLAST = 1'b0; M0_RVALID = 1'b0;
        M1_RID = '0; M1_RDATA = '0; M1_RRESP = '0; M1_RLAST = 1'b0; M1_RVALID = 1'b0;
        S0_RREADY = 1'b0;
        S1_RREADY = 1'b0;
        SD_RREADY = 1'b0;
        if (state == DATA) begin
            if (grant) begin
                M1_RID = sel_rid; M1_RDATA = sel_rdata; M1_RRESP = sel_rresp;
                M1_RLAST = sel_rlast; M1_RVALID = sel_rvalid;
            end else begin
                M0_RID = sel_rid; M0_RDATA = sel_rdata; M0_RRESP = sel_rresp;
                M0_RLAST = sel_rlast; M0_RVALID = sel_rvalid;
            end
            case (sel)
                SEL_S0:  S0_RREADY = grant_rready;
                SEL_S1:  S1_RREADY = grant_rready;
                SEL_SD:  SD_RREADY = grant_rready;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_router.sv
// tb_axi_read_router
// Table of read transactions (master, address, length, expected target,
// slave response) plus hand-written sequences for arbitration ties and a
// reset in the middle of a burst. Expected R beats go through a queue.
module tb_axi_read_router;

    logic ACLK = 1'b0;
    logic ARESETn;

    logic [1:0][3:0]  m_arid;
    logic [1:0][31:0] m_araddr;
    logic [1:0][3:0]  m_arlen;
    logic [1:0][2:0]  m_arsize;
    logic [1:0][1:0]  m_arburst;
    logic [1:0]       m_arvalid;
    logic [1:0]       m_arready;
    logic [1:0][3:0]  m_rid;
    logic [1:0][31:0] m_rdata;
    logic [1:0][1:0]  m_rresp;
    logic [1:0]       m_rlast;
    logic [1:0]       m_rvalid;
    logic [1:0]       m_rready;

    logic [2:0][7:0]  s_arid;
    logic [2:0][31:0] s_araddr;
    logic [2:0][3:0]  s_arlen;
    logic [2:0][2:0]  s_arsize;
    logic [2:0][1:0]  s_arburst;
    logic [2:0]       s_arvalid;
    logic [2:0]       s_arready;
    logic [2:0][7:0]  s_rid;
    logic [2:0][31:0] s_rdata;
    logic [2:0][1:0]  s_rresp;
    logic [2:0]       s_rlast;
    logic [2:0]       s_rvalid;
    logic [2:0]       s_rready;

    axi_read_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARID(m_arid[0]), .M0_ARADDR(m_araddr[0]), .M0_ARLEN(m_arlen[0]), .M0_ARSIZE(m_arsize[0]),
        .M0_ARBURST(m_arburst[0]), .M0_ARVALID(m_arvalid[0]), .M0_ARREADY(m_arready[0]),
        .M0_RID(m_rid[0]), .M0_RDATA(m_rdata[0]), .M0_RRESP(m_rresp[0]), .M0_RLAST(m_rlast[0]),
        .M0_RVALID(m_rvalid[0]), .M0_RREADY(m_rready[0]),
        .M1_ARID(m_arid[1]), .M1_ARADDR(m_araddr[1]), .M1_ARLEN(m_arlen[1]), .M1_ARSIZE(m_arsize[1]),
        .M1_ARBURST(m_arburst[1]), .M1_ARVALID(m_arvalid[1]), .M1_ARREADY(m_arready[1]),
        .M1_RID(m_rid[1]), .M1_RDATA(m_rdata[1]), .M1_RRESP(m_rresp[1]), .M1_RLAST(m_rlast[1]),
        .M1_RVALID(m_rvalid[1]), .M1_RREADY(m_rready[1]),
        .S0_ARID(s_arid[0]), .S0_ARADDR(s_araddr[0]), .S0_ARLEN(s_arlen[0]), .S0_ARSIZE(s_arsize[0]),
        .S0_ARBURST(s_arburst[0]), .S0_ARVALID(s_arvalid[0]), .S0_ARREADY(s_arready[0]),
        .S0_RID(s_rid[0]), .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]), .S0_RLAST(s_rlast[0]),
        .S0_RVALID(s_rvalid[0]), .S0_RREADY(s_rready[0]),
        .S1_ARID(s_arid[1]), .S1_ARADDR(s_araddr[1]), .S1_ARLEN(s_arlen[1]), .S1_ARSIZE(s_arsize[1]),
        .S1_ARBURST(s_arburst[1]), .S1_ARVALID(s_arvalid[1]), .S1_ARREADY(s_arready[1]),
        .S1_RID(s_rid[1]), .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]), .S1_RLAST(s_rlast[1]),
        .S1_RVALID(s_rvalid[1]), .S1_RREADY(s_rready[1]),
        .SD_ARID(s_arid[2]), .SD_ARADDR(s_araddr[2]), .SD_ARLEN(s_arlen[2]), .SD_ARSIZE(s_arsize[2]),
        .SD_ARBURST(s_arburst[2]), .SD_ARVALID(s_arvalid[2]), .SD_ARREADY(s_arready[2]),
        .SD_RID(s_rid[2]), .SD_RDATA(s_rdata[2]), .SD_RRESP(s_rresp[2]), .SD_RLAST(s_rlast[2]),
        .SD_RVALID(s_rvalid[2]), .SD_RREADY(s_rready[2])
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          slv;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_stall;
        int          stall_beat;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    vec_t  vecs[6];
    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_ar(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        m_arid[m]    = id;
        m_araddr[m]  = addr;
        m_arlen[m]   = len;
        m_arsize[m]  = (m != 0) ? 3'd1 : 3'd2;
        m_arburst[m] = (m != 0) ? 2'b10 : 2'b01;
        m_arvalid[m] = 1'b1;
    endtask

    // Called at posedge+1 with the DUT in IDLE and the master's ARVALID up.
    task automatic expect_ar(input int m, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input int slv, input int stall, input bit drop);
        logic       mb;
        logic [2:0] ev;
        logic [1:0] er;
        mb = (m != 0);
        ev = '0;
        ev[slv] = 1'b1;
        @(negedge ACLK);
        check("idle s_arvalid", s_arvalid, 0);
        check("idle m_arready", m_arready, 0);
        check("idle m_rvalid", m_rvalid, 0);
        check("idle s_rready", s_rready, 0);
        s_rvalid = '0;
        s_rlast  = '0;
        m_rready = '0;
        @(posedge ACLK); #1;
        for (int c = 0; c <= stall; c++) begin
            s_arready = 3'b111;
            s_arready[slv] = (c == stall);
            er = '0;
            if (c == stall) er[m] = 1'b1;
            @(negedge ACLK);
            check("s_arvalid", s_arvalid, ev);
            check("s_arid", s_arid[slv], {3'b000, mb, id});
            check("s_araddr", s_araddr[slv], addr);
            check("s_arlen", s_arlen[slv], len);
            check("s_arsize", s_arsize[slv], mb ? 3'd1 : 3'd2);
            check("s_arburst", s_arburst[slv], mb ? 2'b10 : 2'b01);
            check("m_arready", m_arready, er);
            @(posedge ACLK); #1;
        end
        s_arready = '0;
        if (drop) m_arvalid[m] = 1'b0;
    endtask

    // Slave delivers nrun beats; master RREADY drops for 2 cycles on stall_beat.
    task automatic r_burst(input int m, input int slv, input logic [3:0] id, input logic [3:0] len,
                           input logic [31:0] dbase, input logic [1:0] resp, input int stall_beat,
                           input int nrun);
        int         b;
        int         st;
        logic       rr;
        logic       mb;
        logic [2:0] es;
        beat_t      e;
        b  = 0;
        st = 0;
        mb = (m != 0);
        while (b < nrun) begin
            s_rvalid[slv] = 1'b1;
            s_rid[slv]    = {3'b000, mb, id};
            s_rdata[slv]  = dbase + 32'(b);
            s_rresp[slv]  = resp;
            s_rlast[slv]  = (b == int'(len));
            rr = !(b == stall_beat && st < 2);
            m_rready[m]   = rr;
            m_rready[1-m] = 1'b1;
            if (rr) exp_q.push_back('{id, dbase + 32'(b), resp, (b == int'(len))});
            es = '0;
            es[slv] = rr;
            @(negedge ACLK);
            check("m_rvalid granted", m_rvalid[m], 1);
            check("m_rvalid other", m_rvalid[1-m], 0);
            check("s_rready", s_rready, es);
            if (rr) begin
                e = exp_q.pop_front();
                check("m_rdata", m_rdata[m], e.data);
                check("m_rresp", m_rresp[m], e.resp);
                check("m_rlast", m_rlast[m], e.last);
                check("m_rid", m_rid[m], e.id);
            end
            @(posedge ACLK); #1;
            if (rr) b++;
            else st++;
        end
    endtask

    int winners[3];
    int      arb_slv[2];
    logic [3:0]  arb_id[2];
    logic [31:0] arb_addr[2];

    initial begin
        vecs[0] = '{0, 4'h3, 32'h0000_0010, 4'd0, 0, 32'hDEAD_BEEF, 2'b00, 0, -1};
        vecs[1] = '{1, 4'h5, 32'h0001_0004, 4'd3, 1, 32'h1000_0000, 2'b00, 0, 1};
        vecs[2] = '{0, 4'h1, 32'h8000_0000, 4'd0, 2, 32'h0000_0000, 2'b11, 0, -1};
        vecs[3] = '{1, 4'h9, 32'h0000_FFFC, 4'd1, 0, 32'h2222_0000, 2'b00, 5, -1};
        vecs[4] = '{0, 4'hF, 32'h0001_FFFF, 4'd0, 1, 32'hA5A5_5A5A, 2'b10, 0, -1};
        vecs[5] = '{1, 4'h2, 32'h0002_0000, 4'd2, 2, 32'h5555_0000, 2'b11, 0, 0};

        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_arvalid = '0; m_rready = '0;
        s_arready = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0;
        ARESETn = 1'b1;
        #3 ARESETn = 1'b0;

        @(negedge ACLK);
        check("rst m_arready", m_arready, 0);
        check("rst m_rvalid", m_rvalid, 0);
        check("rst s_arvalid", s_arvalid, 0);
        check("rst s_rready", s_rready, 0);
        check("rst m0_rdata", m_rdata[0], 0);
        check("rst m1_rid", m_rid[1], 0);
        check("rst sd_araddr", s_araddr[2], 0);
        check("rst s0_arid", s_arid[0], 0);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;

        for (int i = 0; i < 6; i++) begin
            drive_ar(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len);
            expect_ar(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].slv, vecs[i].ar_stall, 1'b1);
            r_burst(vecs[i].m, vecs[i].slv, vecs[i].id, vecs[i].len, vecs[i].data, vecs[i].resp,
                    vecs[i].stall_beat, int'(vecs[i].len) + 1);
        end

        // Reset after beat 2 of a 4-beat burst; slave keeps RVALID up throughout.
        drive_ar(0, 4'h4, 32'h0000_0020, 4'd3);
        expect_ar(0, 4'h4, 32'h0000_0020, 4'd3, 0, 0, 1'b1);
        r_burst(0, 0, 4'h4, 4'd3, 32'h7000_0000, 2'b00, -1, 2);
        #2 ARESETn = 1'b0;
        #1;
        check("midrst m_rvalid", m_rvalid, 0);
        check("midrst s_rready", s_rready, 0);
        check("midrst m_arready", m_arready, 0);
        check("midrst s_arvalid", s_arvalid, 0);
        check("midrst m0_rdata", m_rdata[0], 0);
        @(negedge ACLK);
        check("midrst hold m_rvalid", m_rvalid, 0);
        check("midrst hold s_rready", s_rready, 0);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Arbitration ties straight after reset.
`ifdef AXI_RR_ARB_EN
        winners = '{0, 1, 0};
`else
        winners = '{1, 1, 0};
`endif
        arb_id   = '{4'h6, 4'h7};
        arb_addr = '{32'h0000_0100, 32'h0001_0100};
        arb_slv  = '{0, 1};
        drive_ar(0, arb_id[0], arb_addr[0], 4'd0);
        drive_ar(1, arb_id[1], arb_addr[1], 4'd0);
        for (int r = 0; r < 3; r++) begin
            expect_ar(winners[r], arb_id[winners[r]], arb_addr[winners[r]], 4'd0,
                      arb_slv[winners[r]], 0, (r != 0));
            r_burst(winners[r], arb_slv[winners[r]], arb_id[winners[r]], 4'd0,
                    32'hC000_0000 + 32'(r), 2'b00, -1, 1);
        end

        // Trailing idle check after the final burst.
        @(negedge ACLK);
        check("final idle m_rvalid", m_rvalid, 0);
        check("final idle s_arvalid", s_arvalid, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
